// File: rtl/i2c_slave_xfer.sv
// I2C slave front end: START/STOP decode, 7-bit address match, byte-wise write delivery, block read streaming.
// Latency: SYNC_STAGES+1 core cycles from a bus pin edge to the resulting state change; rx_valid one cycle after the 8th data rise.
// Backpressure: rx_ready low at the 8th write bit drops the byte and NACKs; the slave never stretches scl.
//
// Ports:
//   clk, n_rst           system clock (rising edge) and asynchronous active-low reset
//   scl, sda_in          bus clock and bus data as seen on the pins (asynchronous)
//   sda_out              open-drain data drive, 0 = pull low, 1 = release
//   tx_data, tx_load     read block (byte 0 in the top byte) and its capture strobe
//   rx_ready             consumer can take the next write byte
//   rx_data, rx_valid    last received write byte and its one-cycle strobe
//   rx_rw                R/W bit of the last matched address (1 = read)
//   start_det, stop_det  one-cycle strobes on (repeated) START and on STOP
//   busy                 set on address match, cleared on STOP, NACK or address mismatch
module i2c_slave_xfer #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h78,
  parameter int         NUM_BYTES   = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   scl,
  input  logic                   sda_in,
  output logic                   sda_out,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  output logic                   tx_load,
  input  logic                   rx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic                   rx_rw,
  output logic                   start_det,
  output logic                   stop_det,
  output logic                   busy
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACKCHK,
    WAIT_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
      r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  // scl must be high on both samples so an sda edge coincident with an scl
  // edge is never mistaken for a bus condition.
  assign w_start    = r_sda_prev & ~w_sda & w_scl & r_scl_prev;
  assign w_stop     = ~r_sda_prev & w_sda & w_scl & r_scl_prev;

  // ---------------------------------------------------------------------------
  // Transfer state
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_ack_drv;   // ACK slot: 0 = waiting for driving fall, 1 = driving
  logic [8*NUM_BYTES-1:0] r_tx_buf;
  logic [IDX_W-1:0]       r_byte_idx;

  logic                   r_sda_out;
  logic                   r_tx_load;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid;
  logic                   r_rx_rw;
  logic                   r_start_det;
  logic                   r_stop_det;
  logic                   r_busy;

  // Byte completed by the current rising edge (MSB first).
  logic [7:0] w_rx_byte;
  assign w_rx_byte = {r_shift[6:0], w_sda};

  // Current read byte; byte 0 sits in the top byte of the captured block.
  logic [7:0] w_tx_byte;
  always_comb begin
    w_tx_byte = r_tx_buf[8*NUM_BYTES-1 -: 8];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (r_byte_idx == IDX_W'(i)) w_tx_byte = r_tx_buf[8*(NUM_BYTES-1-i) +: 8];
    end
  end

  // Bit 7 - r_bit_cnt for counts 0..7.
  logic [2:0] w_bit_idx;
  assign w_bit_idx = ~r_bit_cnt[2:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_ack_drv   <= 1'b0;
      r_tx_buf    <= '0;
      r_byte_idx  <= '0;
      r_sda_out   <= 1'b1;
      r_tx_load   <= 1'b0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_rw     <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tx_load   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;

      if (w_stop) begin
        // STOP takes priority over anything the data path would do this cycle.
        r_state    <= IDLE;
        r_sda_out  <= 1'b1;
        r_busy     <= 1'b0;
        r_stop_det <= 1'b1;
        r_bit_cnt  <= 4'd0;
        r_ack_drv  <= 1'b0;
      end else if (w_start) begin
        // busy is left alone so a repeated START inside a matched transfer keeps it.
        r_state     <= ADDR;
        r_start_det <= 1'b1;
        r_sda_out   <= 1'b1;
        r_bit_cnt   <= 4'd0;
        r_shift     <= 8'd0;
        r_byte_idx  <= '0;
        r_ack_drv   <= 1'b0;
      end else begin
        case (r_state)
          ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_rx_byte;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= 4'd0;
                if (w_rx_byte[7:1] == SLAVE_ADDR) begin
                  r_rx_rw <= w_rx_byte[0];
                  r_busy  <= 1'b1;
                  r_state <= ADDR_ACK;
                end else begin
                  r_busy  <= 1'b0;
                  r_state <= WAIT_STOP;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_ack_drv <= 1'b1;
                r_sda_out <= 1'b0;
                if (r_rx_rw) begin
                  r_tx_buf   <= tx_data;
                  r_tx_load  <= 1'b1;
                  r_byte_idx <= '0;
                end
              end else begin
                r_ack_drv <= 1'b0;
                if (r_rx_rw) begin
                  // The ACK-ending fall also launches bit 7 of byte 0.
                  r_state   <= TX_BYTE;
                  r_sda_out <= r_tx_buf[8*NUM_BYTES-1];
                end else begin
                  r_state   <= RX_BYTE;
                  r_sda_out <= 1'b1;
                end
              end
            end
          end

          RX_BYTE: begin
            if (w_scl_rise) begin
              r_shift <= w_rx_byte;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= 4'd0;
                r_rx_data <= w_rx_byte;
                if (rx_ready) begin
                  r_rx_valid <= 1'b1;
                  r_state    <= RX_ACK;
                end else begin
                  // Consumer full: drop the byte and leave sda released (NACK).
                  r_busy  <= 1'b0;
                  r_state <= WAIT_STOP;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          RX_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_ack_drv <= 1'b1;
                r_sda_out <= 1'b0;
              end else begin
                r_ack_drv <= 1'b0;
                r_sda_out <= 1'b1;
                r_state   <= RX_BYTE;
              end
            end
          end

          TX_BYTE: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_bit_cnt <= 4'd0;
                r_sda_out <= 1'b1;
                r_state   <= TX_ACKCHK;
              end else begin
                r_sda_out <= w_tx_byte[w_bit_idx];
              end
            end
          end

          TX_ACKCHK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_state <= TX_BYTE;
                if (r_byte_idx == IDX_W'(NUM_BYTES - 1)) begin
                  // Block exhausted: wrap and reload so the master keeps streaming.
                  r_byte_idx <= '0;
                  r_tx_buf   <= tx_data;
                  r_tx_load  <= 1'b1;
                end else begin
                  r_byte_idx <= r_byte_idx + 1'b1;
                end
              end else begin
                r_busy  <= 1'b0;
                r_state <= WAIT_STOP;
              end
            end
          end

          default: begin
            // IDLE and WAIT_STOP leave only on START/STOP, handled above.
            r_sda_out <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sda_out   = r_sda_out;
  assign tx_load   = r_tx_load;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_rw     = r_rx_rw;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;
  assign busy      = r_busy;

endmodule
